ram_arbiter: RTL and testbench

RAM_ARBITER -- requirements
Module: ram_arbiter

---
 rtl/ram_arbiter.sv | 128 ++++++++++++
 tb/tb_ram_arbiter.sv | 194 +++++++++++++++++++
 2 files changed

// File: rtl/ram_arbiter.sv
// Two-port read arbiter for a nibble-serial external RAM (addr out, RAM_LATENCY idle, data in).
// Define RAM_ARB_ROUND_ROBIN_EN for round-robin tie-breaking; otherwise port 0 has fixed priority.
module ram_arbiter #(
    parameter int RAM_LATENCY = 1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req0,
    input  logic        req1,
    input  logic [15:0] addr0,
    input  logic [15:0] addr1,
    output logic        ack0,
    output logic        ack1,
    output logic        rvalid0,
    output logic        rvalid1,
    output logic [15:0] rdata,
    output logic [3:0]  addr_bits,
    input  logic [3:0]  data_bits,
    output logic        ram_cs,
    output logic        busy
);

    typedef enum logic [1:0] {IDLE, ADDR, WAIT, DATA} state_t;

    localparam logic [2:0] WAIT_LAST = 3'((RAM_LATENCY > 0) ? RAM_LATENCY - 1 : 0);

    state_t           state, state_nxt;
    logic [1:0]       nib_cnt, nib_nxt;
    logic [2:0]       wait_cnt, wait_nxt;
    logic [3:0][3:0]  laddr;
    logic [3:0][3:0]  shadow;
    logic             owner;
    logic             done;
    logic             accept;
    logic             finish;
    logic             gnt_sel;

`ifdef RAM_ARB_ROUND_ROBIN_EN
    logic last_grant;

    // On a tie, hand the bus to whichever port did not get it last time.
    always_comb gnt_sel = (req0 && req1) ? ~last_grant : req1;

    always_ff @(posedge clk) begin
        if (reset)       last_grant <= 1'b1;
        else if (accept) last_grant <= gnt_sel;
    end
`else
    always_comb gnt_sel = ~req0;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= IDLE;
            nib_cnt  <= 2'd0;
            wait_cnt <= 3'd0;
            laddr    <= '0;
            shadow   <= '0;
            owner    <= 1'b0;
            rdata    <= 16'd0;
            done     <= 1'b0;
        end else begin
            state    <= state_nxt;
            nib_cnt  <= nib_nxt;
            wait_cnt <= wait_nxt;
            done     <= finish;
            if (accept) begin
                laddr <= gnt_sel ? addr1 : addr0;
                owner <= gnt_sel;
            end
            if (state == DATA)
                shadow[nib_cnt] <= data_bits;
            // Last nibble goes straight into rdata so the word is visible in the rvalid cycle.
            if (finish)
                rdata <= {data_bits, shadow[2], shadow[1], shadow[0]};
        end
    end

    always_comb begin
        state_nxt = state;
        nib_nxt   = nib_cnt;
        wait_nxt  = wait_cnt;
        accept    = 1'b0;
        finish    = 1'b0;
        case (state)
            IDLE: begin
                if (req0 || req1) begin
                    accept    = 1'b1;
                    nib_nxt   = 2'd0;
                    state_nxt = ADDR;
                end
            end
            ADDR: begin
                nib_nxt = nib_cnt + 2'd1;
                if (nib_cnt == 2'd3) begin
                    wait_nxt  = 3'd0;
                    state_nxt = (RAM_LATENCY == 0) ? DATA : WAIT;
                end
            end
            WAIT: begin
                wait_nxt = wait_cnt + 3'd1;
                if (wait_cnt == WAIT_LAST) begin
                    wait_nxt  = 3'd0;
                    state_nxt = DATA;
                end
            end
            DATA: begin
                nib_nxt = nib_cnt + 2'd1;
                if (nib_cnt == 2'd3) begin
                    finish    = 1'b1;
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        addr_bits = (state == ADDR) ? laddr[nib_cnt] : 4'd0;
        ram_cs    = (state != IDLE);
        busy      = (state != IDLE);
        ack0      = (state == ADDR) && (nib_cnt == 2'd0) && !owner;
        ack1      = (state == ADDR) && (nib_cnt == 2'd0) &&  owner;
        rvalid0   = done && !owner;
        rvalid1   = done &&  owner;
    end

endmodule

// File: tb/tb_ram_arbiter.sv
// Directed bench: instance 0 uses RAM_LATENCY=1, instance 1 uses RAM_LATENCY=0,
// each with a small nibble-serial RAM model answering on the bus.
module tb_ram_arbiter;

    logic        clk = 1'b0;
    logic        reset_s [2];
    logic        req0_s [2], req1_s [2];
    logic [15:0] addr0_s [2], addr1_s [2];
    logic        ack0_s [2], ack1_s [2], rvalid0_s [2], rvalid1_s [2];
    logic [15:0] rdata_s [2];
    logic [3:0]  addr_bits_s [2], data_bits_s [2];
    logic        ram_cs_s [2], busy_s [2];

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    function automatic logic [15:0] mem_word(input logic [15:0] a);
        return (a == 16'hBEEF) ? 16'h1234 : (a ^ 16'hA5A5);
    endfunction

    for (genvar g = 0; g < 2; g++) begin : g_inst
        localparam int LAT = (g == 0) ? 1 : 0;
        logic [3:0]      mcnt;
        logic [3:0][3:0] mabuf;
        logic [3:0]      dbits;
        logic [15:0]     w;
        int              idx;

        ram_arbiter #(.RAM_LATENCY(LAT)) dut (
            .clk(clk), .reset(reset_s[g]),
            .req0(req0_s[g]), .req1(req1_s[g]),
            .addr0(addr0_s[g]), .addr1(addr1_s[g]),
            .ack0(ack0_s[g]), .ack1(ack1_s[g]),
            .rvalid0(rvalid0_s[g]), .rvalid1(rvalid1_s[g]),
            .rdata(rdata_s[g]), .addr_bits(addr_bits_s[g]),
            .data_bits(data_bits_s[g]), .ram_cs(ram_cs_s[g]), .busy(busy_s[g])
        );

        // RAM model: counts bus cycles since ram_cs rose, collects the address, answers after LAT.
        always_ff @(posedge clk) begin
            if (!ram_cs_s[g]) mcnt <= 4'd0;
            else begin
                mcnt <= mcnt + 4'd1;
                if (mcnt < 4'd4) mabuf[mcnt[1:0]] <= addr_bits_s[g];
            end
        end

        always_comb begin
            dbits = 4'd0;
            w     = mem_word(mabuf);
            idx   = int'(mcnt) - 4 - LAT;
            if (ram_cs_s[g] && idx >= 0 && idx < 4) dbits = w[idx*4 +: 4];
        end
        assign data_bits_s[g] = dbits;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    initial begin
        int rr;
        int w, gap, lows, rv_at, saw1;
        logic [15:0] rd;
`ifdef RAM_ARB_ROUND_ROBIN_EN
        rr = 1;
`else
        rr = 0;
`endif
        for (int g = 0; g < 2; g++) begin
            reset_s[g] = 1'b1; req0_s[g] = 1'b0; req1_s[g] = 1'b0;
            addr0_s[g] = 16'h0; addr1_s[g] = 16'h0;
        end
        tick(); tick();
        for (int g = 0; g < 2; g++) begin
            check("rst_busy",  {31'd0, busy_s[g]}, 0);
            check("rst_cs",    {31'd0, ram_cs_s[g]}, 0);
            check("rst_ack",   {30'd0, ack0_s[g], ack1_s[g]}, 0);
            check("rst_rv",    {30'd0, rvalid0_s[g], rvalid1_s[g]}, 0);
            check("rst_rdata", {16'd0, rdata_s[g]}, 0);
            check("rst_addr",  {28'd0, addr_bits_s[g]}, 0);
            reset_s[g] = 1'b0;
        end

        // Single read, latency 1: addr_bits F,E,E,B then data 4,3,2,1 -> 0x1234.
        req0_s[0] = 1'b1; addr0_s[0] = 16'hBEEF;
        for (int n = 1; n <= 11; n++) begin
            tick();
            check("t1_ack0", {31'd0, ack0_s[0]}, (n == 1) ? 1 : 0);
            check("t1_ack1", {31'd0, ack1_s[0]}, 0);
            check("t1_addr", {28'd0, addr_bits_s[0]},
                  (n == 1) ? 32'hF : (n == 2 || n == 3) ? 32'hE : (n == 4) ? 32'hB : 32'h0);
            check("t1_cs",   {31'd0, ram_cs_s[0]}, (n <= 9) ? 1 : 0);
            check("t1_rv0",  {31'd0, rvalid0_s[0]}, (n == 10) ? 1 : 0);
            if (n >= 10) check("t1_rdata", {16'd0, rdata_s[0]}, 32'h1234);
            req0_s[0] = 1'b0;
        end

        // Latency 0 on port 1: DATA follows ADDR directly, rvalid1 at t+9.
        req1_s[1] = 1'b1; addr1_s[1] = 16'h0001;
        for (int n = 1; n <= 10; n++) begin
            tick();
            check("t2_ack1", {31'd0, ack1_s[1]}, (n == 1) ? 1 : 0);
            check("t2_ack0", {31'd0, ack0_s[1]}, 0);
            check("t2_addr", {28'd0, addr_bits_s[1]}, (n == 1) ? 1 : 0);
            check("t2_cs",   {31'd0, ram_cs_s[1]}, (n <= 8) ? 1 : 0);
            check("t2_rv1",  {31'd0, rvalid1_s[1]}, (n == 9) ? 1 : 0);
            if (n >= 9) check("t2_rdata", {16'd0, rdata_s[1]}, 32'hA5A4);
            req1_s[1] = 1'b0;
        end

        // Contention from a fresh reset, both requests held for four grants.
        reset_s[0] = 1'b1; tick(); reset_s[0] = 1'b0;
        req0_s[0] = 1'b1; req1_s[0] = 1'b1; addr0_s[0] = 16'h1111; addr1_s[0] = 16'h2222;
        for (int i = 0; i < 4; i++) begin
            w = 0;
            do begin
                tick(); w++;
                check("cont_excl", {31'd0, ack0_s[0] & ack1_s[0]}, 0);
            end while (!(ack0_s[0] || ack1_s[0]) && w < 30);
            check("cont_timeout", (w < 30) ? 1 : 0, 1);
            check("cont_grant", {31'd0, ack1_s[0]}, rr ? (i % 2) : 0);
        end
        req0_s[0] = 1'b0; req1_s[0] = 1'b0;
        for (int i = 0; i < 12; i++) tick();

        // Back-to-back on port 0 with req held.
        req0_s[0] = 1'b1; addr0_s[0] = 16'h00F0;
        w = 0;
        do begin tick(); w++; end while (!ack0_s[0] && w < 30);
        check("b2b_first", (w < 30) ? 1 : 0, 1);
        gap = 0; lows = 0; rd = 16'h0;
        do begin
            tick(); gap++;
            if (!ram_cs_s[0]) lows++;
            if (rvalid0_s[0]) rd = rdata_s[0];
        end while (!ack0_s[0] && gap < 30);
        check("b2b_period", gap, 10);
        check("b2b_cs_low", lows, 1);
        check("b2b_rdata", {16'd0, rd}, 32'hA555);
        req0_s[0] = 1'b0;
        for (int i = 0; i < 12; i++) tick();

        // Reset during DATA nibble 2 abandons the read.
        req0_s[0] = 1'b1; addr0_s[0] = 16'hBEEF;
        for (int n = 1; n <= 8; n++) begin tick(); req0_s[0] = 1'b0; end
        reset_s[0] = 1'b1;
        tick();
        check("mid_busy",  {31'd0, busy_s[0]}, 0);
        check("mid_cs",    {31'd0, ram_cs_s[0]}, 0);
        check("mid_addr",  {28'd0, addr_bits_s[0]}, 0);
        check("mid_ack",   {30'd0, ack0_s[0], ack1_s[0]}, 0);
        check("mid_rv",    {30'd0, rvalid0_s[0], rvalid1_s[0]}, 0);
        check("mid_rdata", {16'd0, rdata_s[0]}, 0);
        reset_s[0] = 1'b0;
        tick();
        check("mid_rv_after", {31'd0, rvalid0_s[0]}, 0);
        req0_s[0] = 1'b1;
        w = 0;
        do begin tick(); w++; req0_s[0] = 1'b0; end while (!rvalid0_s[0] && w < 30);
        check("mid_new_lat", w, 10);
        check("mid_new_rdata", {16'd0, rdata_s[0]}, 32'h1234);

        // req1 pulsed while port 0 owns the bus: never acked.
        tick();
        req0_s[0] = 1'b1; addr0_s[0] = 16'h0F00; addr1_s[0] = 16'h2222;
        saw1 = 0; rv_at = 0; rd = 16'h0;
        for (int n = 1; n <= 12; n++) begin
            tick();
            if (ack1_s[0] || rvalid1_s[0]) saw1 = 1;
            if (rvalid0_s[0]) begin rv_at = n; rd = rdata_s[0]; end
            if (n == 1) req0_s[0] = 1'b0;
            if (n == 3) req1_s[0] = 1'b1;
            if (n == 8) req1_s[0] = 1'b0;
        end
        check("ign_req1", saw1, 0);
        check("ign_rv0_at", rv_at, 10);
        check("ign_rdata", {16'd0, rd}, 32'hAAA5);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
